// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 register file slice.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: register/data widths, XZR index, address/data/mask typedefs and
// the per-port load-use hazard function used by the stall logic.
package regfile_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;
    typedef logic [NREG-1:0]       reg_mask_t;

    // One read port waits when it really consumes an operand whose load is
    // still outstanding, unless the writeback of that same register lands
    // this cycle (the bypass then supplies the value).
    function automatic logic port_hazard(
        input logic      use_op,
        input reg_addr_t ra,
        input reg_mask_t busy,
        input logic      wb_en,
        input reg_addr_t wa,
        input reg_addr_t zero_idx
    );
        return use_op && (ra != zero_idx) && busy[ra] && !(wb_en && (wa == ra));
    endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// Bundle of the write, read, load-issue and scoreboard signals of regfile_bank.
// Latency: n/a (wiring only). Backpressure: stall is the only hold signal, toward decode.
// Modports: master = decode/writeback side (drives requests, sees data/stall),
//           slave  = register file (consumes requests, returns data/busy/stall).
interface regfile_bank_if;
    import regfile_pkg::*;

    // writeback port
    logic      we;
    reg_addr_t wa;
    reg_data_t wd;

    // decode read ports
    reg_addr_t ra1;
    reg_addr_t ra2;
    logic      use1;
    logic      use2;

    // load issue
    logic      ld_issue;
    reg_addr_t ld_dest;

    // results
    reg_data_t rd1;
    reg_data_t rd2;
    reg_mask_t busy;
    logic      stall;

    modport master (
        output we, wa, wd,
        output ra1, ra2, use1, use2,
        output ld_issue, ld_dest,
        input  rd1, rd2, busy, stall
    );

    modport slave (
        input  we, wa, wd,
        input  ra1, ra2, use1, use2,
        input  ld_issue, ld_dest,
        output rd1, rd2, busy, stall
    );

endinterface

// File: rtl/reg_read_port.sv
// One combinational read port: 32:1 select over storage, write-through bypass, XZR forced to zero.
// Latency: zero cycles (purely combinational). Backpressure: none.
// Ports: regs (flattened storage), ra (read address), byp_en/wa/wd (writeback
//        for same-cycle bypass), rd (read data).
module reg_read_port
    import regfile_pkg::*;
#(
    parameter int        W    = 64,
    parameter int        N    = 32,
    parameter reg_addr_t ZERO = 5'd31
) (
    input  logic [N-1:0][W-1:0] regs,
    input  reg_addr_t           ra,
    input  logic                byp_en,
    input  reg_addr_t           wa,
    input  logic [W-1:0]        wd,
    output logic [W-1:0]        rd
);

    // Priority, lowest to highest: stored value, bypassed write data, zero register.
    // The zero check is last so a (discarded) write to XZR can never leak through
    // the bypass path.
    always_comb begin
        rd = regs[ra];
        if (byp_en && (wa == ra)) begin
            rd = wd;
        end
        if (ra == ZERO) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// LEGv8 32x64 register file: storage, one sync write port, two bypassed combinational reads, load-use scoreboard.
// Latency: writes and busy updates take effect at the next rising clk; reads and stall are combinational.
// Backpressure: stall tells decode to hold when a consumed operand still has an outstanding load.
// Ports: clk, rst (async, active-high), bus (regfile_bank_if.slave: we/wa/wd, ra1/ra2,
//        use1/use2, ld_issue/ld_dest in; rd1/rd2, busy, stall out).
module regfile_bank #(
    parameter int                      DATA_W   = regfile_pkg::DATA_W,
    parameter int                      NREG     = regfile_pkg::NREG,
    parameter regfile_pkg::reg_addr_t  ZERO_REG = regfile_pkg::XZR
) (
    input  logic           clk,
    input  logic           rst,
    regfile_bank_if.slave  bus
);
    import regfile_pkg::*;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0]             busy_q;
    logic [NREG-1:0]             busy_nxt;
    logic                        wr_en;
    logic                        byp_en;
    logic [DATA_W-1:0]           rd1;
    logic [DATA_W-1:0]           rd2;
    logic                        hz1;
    logic                        hz2;

    // Writes to the zero register are dropped so its storage slot stays 0.
    assign wr_en = bus.we && (bus.wa != ZERO_REG);

    // While reset is held the outputs must read as zero, so the combinational
    // bypass is suppressed along with the (already cleared) storage.
    assign byp_en = bus.we && !rst;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // ------------------------------------------------------------------
    // Load-use scoreboard
    // ------------------------------------------------------------------
    // Clear on writeback first, then set on load issue, so an issue and a
    // writeback to the same register in one cycle leaves it busy (the new
    // load is still in flight). Bit for the zero register is pinned low.
    always_comb begin
        busy_nxt = busy_q;
        if (bus.we) begin
            busy_nxt[bus.wa] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_dest != ZERO_REG)) begin
            busy_nxt[bus.ld_dest] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    reg_read_port #(
        .W    (DATA_W),
        .N    (NREG),
        .ZERO (ZERO_REG)
    ) u_read_port1 (
        .regs   (regs),
        .ra     (bus.ra1),
        .byp_en (byp_en),
        .wa     (bus.wa),
        .wd     (bus.wd),
        .rd     (rd1)
    );

    reg_read_port #(
        .W    (DATA_W),
        .N    (NREG),
        .ZERO (ZERO_REG)
    ) u_read_port2 (
        .regs   (regs),
        .ra     (bus.ra2),
        .byp_en (byp_en),
        .wa     (bus.wa),
        .wd     (bus.wd),
        .rd     (rd2)
    );

    // ------------------------------------------------------------------
    // Stall: a port hazards only if decode really uses it this cycle.
    // ------------------------------------------------------------------
    assign hz1 = port_hazard(bus.use1, bus.ra1, busy_q, byp_en, bus.wa, ZERO_REG);
    assign hz2 = port_hazard(bus.use2, bus.ra2, busy_q, byp_en, bus.wa, ZERO_REG);

    assign bus.rd1   = rd1;
    assign bus.rd2   = rd2;
    assign bus.busy  = busy_q;
    assign bus.stall = hz1 || hz2;

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank with directed scenarios and a randomized run against a reference model.
// Latency: checks combinational outputs 1-2 time units after input changes; state after each rising edge.
// Backpressure: stall is compared against the model every checked cycle.
module tb_regfile_bank;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    regfile_bank_if bus ();

    regfile_bank #(
        .DATA_W   (64),
        .NREG     (32),
        .ZERO_REG (5'd31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents and the set of
    // registers with a load in flight.
    logic [63:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        m_busy = 32'd0;
    endtask

    // What a consumer should see when reading register ra right now.
    function automatic logic [63:0] m_read(input logic [4:0] ra);
        if (ra == 5'd31) return 64'd0;
        if (bus.we && bus.wa == ra) return bus.wd;
        return m_regs[ra];
    endfunction

    // Does reading ra right now have to wait for an in-flight load?
    function automatic logic m_waits(input logic [4:0] ra);
        return (ra != 5'd31) && m_busy[ra] && !(bus.we && bus.wa == ra);
    endfunction

    function automatic logic m_stall();
        return (bus.use1 && m_waits(bus.ra1)) || (bus.use2 && m_waits(bus.ra2));
    endfunction

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_edge();
        if (bus.we && bus.wa != 5'd31) m_regs[bus.wa] = bus.wd;
        if (bus.we) m_busy[bus.wa] = 1'b0;
        if (bus.ld_issue && bus.ld_dest != 5'd31) m_busy[bus.ld_dest] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.wa = 5'd0; bus.wd = 64'd0;
        bus.ra1 = 5'd0; bus.ra2 = 5'd0; bus.use1 = 1'b0; bus.use2 = 1'b0;
        bus.ld_issue = 1'b0; bus.ld_dest = 5'd0;
    endtask

    function automatic logic [4:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        return (r == 9) ? 5'd31 : 5'(r);
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle();
        bus.ra1 = 5'd5; bus.ra2 = 5'd17;
        #1 rst = 1'b1;
        model_clear();
        #1;
        checks++; if (bus.rd1 !== 64'd0) begin errors++; $display("FAIL rst_init_rd1 got=%h exp=%h", bus.rd1, 64'd0); end
        checks++; if (bus.rd2 !== 64'd0) begin errors++; $display("FAIL rst_init_rd2 got=%h exp=%h", bus.rd2, 64'd0); end
        checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL rst_init_busy got=%h exp=%h", bus.busy, 32'd0); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_init_stall got=%b exp=0", bus.stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_write_read();
        logic [63:0] exp;
        exp = 64'h0123_4567_89AB_CDEF;
        idle();
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = exp;
        tick();
        idle();
        bus.ra1 = 5'd3; bus.ra2 = 5'd3;
        #1;
        checks++; if (bus.rd1 !== exp) begin errors++; $display("FAIL wr_rd1 got=%h exp=%h", bus.rd1, exp); end
        checks++; if (bus.rd2 !== exp) begin errors++; $display("FAIL wr_rd2 got=%h exp=%h", bus.rd2, exp); end
        tick();
    endtask

    task automatic test_xzr();
        idle();
        bus.we = 1'b1; bus.wa = 5'd31; bus.wd = '1; bus.ra1 = 5'd31;
        #1;
        checks++; if (bus.rd1 !== 64'd0) begin errors++; $display("FAIL xzr_same_cycle got=%h exp=%h", bus.rd1, 64'd0); end
        tick();
        bus.we = 1'b0;
        #1;
        checks++; if (bus.rd1 !== 64'd0) begin errors++; $display("FAIL xzr_after got=%h exp=%h", bus.rd1, 64'd0); end
        bus.ld_issue = 1'b1; bus.ld_dest = 5'd31;
        tick();
        idle();
        #1;
        checks++; if (bus.busy[31] !== 1'b0) begin errors++; $display("FAIL xzr_busy31 got=%b exp=0", bus.busy[31]); end
        checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL xzr_busy got=%h exp=%h", bus.busy, m_busy); end
    endtask

    task automatic test_bypass();
        idle();
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 64'h10;
        tick();
        bus.wd = 64'h20; bus.ra2 = 5'd7; bus.ra1 = 5'd7;
        #1;
        checks++; if (bus.rd2 !== 64'h20) begin errors++; $display("FAIL byp_rd2 got=%h exp=%h", bus.rd2, 64'h20); end
        tick();
        bus.we = 1'b0;
        #1;
        checks++; if (bus.rd2 !== 64'h20) begin errors++; $display("FAIL byp_stored got=%h exp=%h", bus.rd2, 64'h20); end
        checks++; if (bus.rd1 !== m_read(5'd7)) begin errors++; $display("FAIL byp_rd1 got=%h exp=%h", bus.rd1, m_read(5'd7)); end
        idle();
    endtask

    task automatic test_load_use();
        logic [63:0] v;
        v = {$urandom, $urandom};
        idle();
        bus.ld_issue = 1'b1; bus.ld_dest = 5'd9;
        tick();
        idle();
        #1;
        checks++; if (bus.busy[9] !== 1'b1) begin errors++; $display("FAIL lu_busy_set got=%b exp=1", bus.busy[9]); end
        bus.ra1 = 5'd9; bus.use1 = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", bus.stall); end
        bus.use1 = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_nouse got=%b exp=0", bus.stall); end
        bus.use1 = 1'b1; bus.we = 1'b1; bus.wa = 5'd9; bus.wd = v;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_wb_stall got=%b exp=0", bus.stall); end
        checks++; if (bus.rd1 !== v) begin errors++; $display("FAIL lu_wb_rd1 got=%h exp=%h", bus.rd1, v); end
        tick();
        bus.we = 1'b0;
        #1;
        checks++; if (bus.busy[9] !== 1'b0) begin errors++; $display("FAIL lu_busy_clr got=%b exp=0", bus.busy[9]); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_after got=%b exp=0", bus.stall); end
        idle();
    endtask

    task automatic test_collision();
        logic [63:0] v;
        v = {$urandom, $urandom};
        idle();
        bus.ld_issue = 1'b1; bus.ld_dest = 5'd4;
        tick();
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = v;
        tick();
        idle();
        bus.ra1 = 5'd4;
        #1;
        checks++; if (bus.busy[4] !== 1'b1) begin errors++; $display("FAIL coll_busy got=%b exp=1", bus.busy[4]); end
        checks++; if (bus.rd1 !== v) begin errors++; $display("FAIL coll_data got=%h exp=%h", bus.rd1, v); end
        // drain it so later tests start from a clean scoreboard
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = v;
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [63:0] e1, e2;
        logic        es;
        for (int n = 0; n < 400; n++) begin
            bus.we       = ($urandom_range(0, 2) == 0);
            bus.wa       = rand_addr();
            bus.wd       = {$urandom, $urandom};
            bus.ra1      = rand_addr();
            bus.ra2      = ($urandom_range(0, 4) == 0) ? bus.ra1 : rand_addr();
            bus.use1     = $urandom_range(0, 1) == 1;
            bus.use2     = $urandom_range(0, 1) == 1;
            bus.ld_issue = ($urandom_range(0, 3) == 0);
            bus.ld_dest  = rand_addr();
            #1;
            e1 = m_read(bus.ra1);
            e2 = m_read(bus.ra2);
            es = m_stall();
            checks++; if (bus.rd1 !== e1) begin errors++; $display("FAIL rnd_rd1 n=%0d ra=%0d got=%h exp=%h", n, bus.ra1, bus.rd1, e1); end
            checks++; if (bus.rd2 !== e2) begin errors++; $display("FAIL rnd_rd2 n=%0d ra=%0d got=%h exp=%h", n, bus.ra2, bus.rd2, e2); end
            checks++; if (bus.stall !== es) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.stall, es); end
            checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, bus.busy, m_busy); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        idle();
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 64'hDEAD;
        tick();
        idle();
        bus.ld_issue = 1'b1; bus.ld_dest = 5'd6;
        tick();
        idle();
        bus.ra1 = 5'd5; bus.ra2 = 5'd6; bus.use2 = 1'b1;
        #1;
        checks++; if (bus.rd1 !== 64'hDEAD) begin errors++; $display("FAIL mid_pre_rd1 got=%h exp=%h", bus.rd1, 64'hDEAD); end
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%b exp=1", bus.stall); end
        rst = 1'b1;
        model_clear();
        #1;
        checks++; if (bus.rd1 !== 64'd0) begin errors++; $display("FAIL mid_rst_rd1 got=%h exp=%h", bus.rd1, 64'd0); end
        checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL mid_rst_busy got=%h exp=%h", bus.busy, 32'd0); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got=%b exp=0", bus.stall); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.rd1 !== 64'd0) begin errors++; $display("FAIL mid_post_rd1 got=%h exp=%h", bus.rd1, 64'd0); end
        checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL mid_post_busy got=%h exp=%h", bus.busy, 32'd0); end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_write_read();
        test_xzr();
        test_bypass();
        test_load_use();
        test_collision();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
